// File: rtl/pulse_train_pkg.sv
// Shared definitions for the pulse train generator.
//   state_e         : FSM state encoding (idle, high phase, low phase), 2 bits
//   CntWDefault     : default width of length/count fields and counters
//   clamp_len()     : treats a zero length as one cycle
// Optional feature macro used elsewhere: PULSE_TRAIN_MARK_EN (edge marker outputs).
package pulse_train_pkg;

  localparam int unsigned CntWDefault = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } state_e;

  function automatic int unsigned clamp_len(input int unsigned len);
    return (len == 0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/pulse_train_gen_if.sv
// Control/status bundle of the pulse train generator.
//   start, stop              : train request / abort
//   high_len, low_len, count : train shape, latched on an accepted start
//   out_sig, busy, done      : waveform and status
//   rise_mark, fall_mark     : edge markers, only with PULSE_TRAIN_MARK_EN defined
// master = the side that requests trains, slave = the generator.
interface pulse_train_gen_if
  import pulse_train_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
);

  logic             start;
  logic             stop;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] count;
  logic             out_sig;
  logic             busy;
  logic             done;
`ifdef PULSE_TRAIN_MARK_EN
  logic             rise_mark;
  logic             fall_mark;

  modport master (
    output start, stop, high_len, low_len, count,
    input  out_sig, busy, done, rise_mark, fall_mark
  );

  modport slave (
    input  start, stop, high_len, low_len, count,
    output out_sig, busy, done, rise_mark, fall_mark
  );
`else
  modport master (
    output start, stop, high_len, low_len, count,
    input  out_sig, busy, done
  );

  modport slave (
    input  start, stop, high_len, low_len, count,
    output out_sig, busy, done
  );
`endif

endinterface

// File: rtl/pulse_train_gen_phase_counter.sv
// Loadable down-counter with a terminal flag.
//   clk, rst  : clock, synchronous active-high reset (clears count)
//   load      : load load_val (has priority over dec)
//   load_val  : value to load (length minus one)
//   dec       : decrement; saturates at zero so it can never wrap
//   zero      : count is zero
module phase_counter
  import pulse_train_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: emits count pulses of high_len high cycles followed by
// low_len low cycles (count = 0 runs until stop). Zero lengths act as one.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, highest priority
//   bus  : pulse_train_gen_if slave modport (start/stop/fields in,
//          out_sig/busy/done out, plus rise_mark/fall_mark when
//          PULSE_TRAIN_MARK_EN is defined)
// All outputs are registered and decoded from the next state in the same stage,
// so out_sig rises the cycle after start is sampled.
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic              clk,
  input  logic              rst,
  pulse_train_gen_if.slave  bus
);

  function automatic logic [CNT_W-1:0] len_load(input logic [CNT_W-1:0] len);
    return CNT_W'(clamp_len(32'(len)) - 32'd1);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] high_q, low_q;  // latched lengths, already clamped minus one
  logic             cont_q;          // count was zero: run until stopped
  logic             out_q, busy_q, done_q;

  logic             accept, hi_end, lo_end, last;
  logic             ph_load, ph_dec, ph_zero;
  logic [CNT_W-1:0] ph_val;
  logic             pc_load, pc_dec, pc_zero;

  always_comb begin
    accept = (state_q == StIdle) && bus.start && !bus.stop;
    hi_end = (state_q == StHigh) && ph_zero;
    lo_end = (state_q == StLow) && ph_zero;
    last   = lo_end && !cont_q && pc_zero;

    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StHigh;
      StHigh: begin
        if (bus.stop)    state_d = StIdle;
        else if (hi_end) state_d = StLow;
      end
      StLow: begin
        if (bus.stop)    state_d = StIdle;
        else if (lo_end) state_d = last ? StIdle : StHigh;
      end
      default: state_d = StIdle;
    endcase

    // Phase counter reloads at every phase boundary; it counts the cycles left.
    ph_load = accept || (!bus.stop && (hi_end || (lo_end && !last)));
    if (accept)      ph_val = len_load(bus.high_len);
    else if (hi_end) ph_val = low_q;
    else             ph_val = high_q;
    ph_dec = (state_q != StIdle);

    // Pulse counter holds pulses remaining after the current one.
    pc_load = accept;
    pc_dec  = lo_end && !cont_q && !bus.stop;
  end

  phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (ph_dec),
    .zero     (ph_zero)
  );

  // count = 0 loads zero here; cont_q makes the terminal flag irrelevant then.
  phase_counter #(.CNT_W(CNT_W)) u_pulse_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (len_load(bus.count)),
    .dec      (pc_dec),
    .zero     (pc_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      high_q  <= '0;
      low_q   <= '0;
      cont_q  <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        high_q <= len_load(bus.high_len);
        low_q  <= len_load(bus.low_len);
        cont_q <= (bus.count == '0);
      end
      out_q  <= (state_d == StHigh);
      busy_q <= (state_d != StIdle);
      done_q <= last && !bus.stop;
    end
  end

  assign bus.out_sig = out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

`ifdef PULSE_TRAIN_MARK_EN
  logic rise_q, fall_q;

  // Compare the next waveform value with the current one so markers line up
  // with out_sig, including the fall forced by stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= (state_d == StHigh) && !out_q;
      fall_q <= (state_d != StHigh) && out_q;
    end
  end

  assign bus.rise_mark = rise_q;
  assign bus.fall_mark = fall_q;
`endif

endmodule

// File: tb/tb_pulse_train_gen.sv
module tb_pulse_train_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pulse_train_gen_if #(.CNT_W(16)) bus ();

  pulse_train_gen #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input bit eo, input bit eb, input bit ed,
                               input bit er, input bit ef);
    check({tag, " out_sig"}, bus.out_sig, eo);
    check({tag, " busy"}, bus.busy, eb);
    check({tag, " done"}, bus.done, ed);
`ifdef PULSE_TRAIN_MARK_EN
    check({tag, " rise_mark"}, bus.rise_mark, er);
    check({tag, " fall_mark"}, bus.fall_mark, ef);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check_outputs("reset_between", 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  // Reference: pulse k occupies cycles k*p+1 .. k*p+H high and the next L low,
  // done one cycle after the last low cycle; stop clears everything next cycle.
  task automatic run_train(input string tag, input int h, input int l, input int n,
                           input int stop_at, input int ign, input bit restart,
                           input int cyc);
    int hh, ll, p, tt, train;
    bit eo, eb, ed, prev;
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    p = hh + ll;
    train = n * p;
    prev = 1'b0;
    bus.high_len = 16'(h);
    bus.low_len  = 16'(l);
    bus.count    = 16'(n);
    bus.start    = 1'b1;
    bus.stop     = 1'b0;
    for (int t = 1; t <= cyc; t++) begin
      tick();
      tt = t;
      if (restart && t > train + 1) tt = t - (train + 1);
      if (stop_at > 0 && t > stop_at) begin
        eo = 0; eb = 0; ed = 0;
      end else if (n != 0 && tt > train) begin
        eo = 0; eb = 0; ed = (tt == train + 1);
      end else begin
        eo = (((tt - 1) % p) < hh); eb = 1; ed = 0;
      end
      check_outputs($sformatf("%s t=%0d", tag, t), eo, eb, ed, eo && !prev, !eo && prev);
      prev = eo;
      bus.stop = (t == stop_at);
      if (restart && t == train + 1) begin
        bus.start    = 1'b1;
        bus.high_len = 16'(h);
        bus.low_len  = 16'(l);
        bus.count    = 16'(n);
      end else begin
        bus.start    = (t == ign);
        bus.high_len = 16'($urandom_range(0, 7));
        bus.low_len  = 16'($urandom_range(0, 7));
        bus.count    = 16'($urandom_range(0, 7));
      end
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    int h, l, n, p, stop_at, ign, cyc;
    bit restart;

    bus.start    = 1'b1;
    bus.stop     = 1'b0;
    bus.high_len = 16'd2;
    bus.low_len  = 16'd2;
    bus.count    = 16'd1;

    // Reset held with start asserted.
    rst = 1'b1;
    repeat (3) begin
      tick();
      check_outputs("reset_hold", 0, 0, 0, 0, 0);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    check_outputs("post_reset", 0, 0, 0, 0, 0);

    // Single pulse, ignored start mid-train, restart in the done cycle.
    run_train("basic", 2, 3, 1, 0, 3, 1'b1, 12);
    do_reset();
    run_train("three", 1, 1, 3, 0, 0, 1'b0, 9);
    do_reset();
    run_train("clamp", 0, 0, 3, 0, 0, 1'b0, 9);
    do_reset();
    run_train("cont_stop_low", 3, 2, 0, 10, 4, 1'b0, 14);
    do_reset();
    run_train("cont_stop_high", 3, 2, 0, 11, 0, 1'b0, 14);
    do_reset();

    // start and stop together in idle: stop wins; stop alone has no effect.
    bus.high_len = 16'd2;
    bus.low_len  = 16'd2;
    bus.count    = 16'd1;
    bus.start    = 1'b1;
    bus.stop     = 1'b1;
    tick();
    check_outputs("start_stop_idle", 0, 0, 0, 0, 0);
    bus.start = 1'b0;
    tick();
    check_outputs("stop_only_idle", 0, 0, 0, 0, 0);
    bus.stop = 1'b0;
    tick();
    check_outputs("idle_after_stop", 0, 0, 0, 0, 0);

    // Reset mid-train: zeros next cycle, no done afterwards.
    bus.high_len = 16'd2;
    bus.low_len  = 16'd3;
    bus.count    = 16'd1;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    check_outputs("midrst t=1", 1, 1, 0, 1, 0);
    tick();
    tick();
    check_outputs("midrst t=3", 0, 1, 0, 0, 1);
    rst = 1'b1;
    tick();
    check_outputs("midrst t=4", 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int t = 5; t <= 8; t++) begin
      tick();
      check_outputs($sformatf("midrst t=%0d", t), 0, 0, 0, 0, 0);
    end

    // Randomized trains.
    for (int i = 0; i < 12; i++) begin
      h = int'($urandom_range(0, 4));
      l = int'($urandom_range(0, 4));
      n = int'($urandom_range(0, 3));
      p = ((h == 0) ? 1 : h) + ((l == 0) ? 1 : l);
      if (n == 0) begin
        restart = 1'b0;
        stop_at = int'($urandom_range(1, 3 * p));
        cyc = stop_at + 3;
      end else begin
        restart = 1'($urandom_range(0, 1));
        stop_at = (!restart && ($urandom_range(0, 1) == 1)) ? int'($urandom_range(1, n * p)) : 0;
        cyc = restart ? 2 * n * p + 3 : n * p + 3;
      end
      ign = int'($urandom_range(1, (stop_at > 0) ? stop_at : n * p));
      run_train($sformatf("rand%0d", i), h, l, n, stop_at, ign, restart, cyc);
      do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
